// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcode encodings, flag bit positions and the
// decode that says which flags an opcode writes.
package wisc_pkg;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_XOR    = 4'b0010;
   localparam logic [3:0] OP_RED    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRA    = 4'b0101;
   localparam logic [3:0] OP_ROR    = 4'b0110;
   localparam logic [3:0] OP_PADDSB = 4'b0111;
   localparam logic [3:0] OP_LW     = 4'b1000;
   localparam logic [3:0] OP_SW     = 4'b1001;
   localparam logic [3:0] OP_LHB    = 4'b1010;
   localparam logic [3:0] OP_LLB    = 4'b1011;
   localparam logic [3:0] OP_B      = 4'b1100;
   localparam logic [3:0] OP_BR     = 4'b1101;
   localparam logic [3:0] OP_PCS    = 4'b1110;
   localparam logic [3:0] OP_HLT    = 4'b1111;

   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   typedef enum logic [1:0] {
      FC_NONE = 2'd0,
      FC_Z    = 2'd1,
      FC_ZVN  = 2'd2
   } flag_class_e;

   function automatic flag_class_e flag_class(input logic [3:0] op);
      flag_class_e cls;
      case (op)
         OP_ADD, OP_SUB:                 cls = FC_ZVN;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: cls = FC_Z;
         default:                        cls = FC_NONE;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/ex_mem_flag_stage_if.sv
// EX->MEM bundle: EX-side instruction fields in, MEM-side registered fields
// and the flag state/bypass out. The stage itself connects to the slave side.
interface ex_mem_flag_stage_if #(
   parameter int DW = 16,
   parameter int RW = 4
);
   logic          stall;
   logic          flush;
   logic          ex_valid;
   logic [3:0]    ex_opcode;
   logic [DW-1:0] ex_result;
   logic          ex_ovfl;
   logic [DW-1:0] ex_store_data;
   logic [RW-1:0] ex_rd;
   logic          ex_reg_wr;
   logic          ex_mem_rd;
   logic          ex_mem_wr;
   logic          ex_halt;

   logic          mem_valid;
   logic          mem_reg_wr;
   logic          mem_mem_rd;
   logic          mem_mem_wr;
   logic          mem_halt;
   logic [3:0]    mem_opcode;
   logic [DW-1:0] mem_result;
   logic [DW-1:0] mem_store_data;
   logic [RW-1:0] mem_rd;

   logic          flag_z;
   logic          flag_v;
   logic          flag_n;
   logic [2:0]    flags_fwd;

   modport master (
      output stall, flush, ex_valid, ex_opcode, ex_result, ex_ovfl,
             ex_store_data, ex_rd, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_halt,
      input  mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_halt,
             mem_opcode, mem_result, mem_store_data, mem_rd,
             flag_z, flag_v, flag_n, flags_fwd
   );

   modport slave (
      input  stall, flush, ex_valid, ex_opcode, ex_result, ex_ovfl,
             ex_store_data, ex_rd, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_halt,
      output mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_halt,
             mem_opcode, mem_result, mem_store_data, mem_rd,
             flag_z, flag_v, flag_n, flags_fwd
   );
endinterface

// File: rtl/ex_mem_flag_stage_flag_reg.sv
// Architectural Z/V/N flags: per-bit write enables decoded from the EX opcode,
// the flag flops, and the bypass that lets a branch in ID see this edge's update.
module flag_reg
   import wisc_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_qual,
   input  logic [3:0]    opcode,
   input  logic [DW-1:0] result,
   input  logic          ovfl,
   output logic [2:0]    flags,
   output logic [2:0]    flags_fwd
);

   logic [2:0]  we;
   logic [2:0]  new_flags;
   flag_class_e cls;

   always_comb begin
      cls               = flag_class(opcode);
      we                = 3'b000;
      new_flags         = 3'b000;
      new_flags[FLAG_Z] = (result == '0);
      new_flags[FLAG_V] = ovfl;
      new_flags[FLAG_N] = result[DW-1];
      if (wr_qual) begin
         case (cls)
            FC_ZVN:  we = 3'b111;
            FC_Z:    we[FLAG_Z] = 1'b1;
            default: we = 3'b000;
         endcase
      end
      for (int i = 0; i < 3; i++) begin
         flags_fwd[i] = we[i] ? new_flags[i] : flags[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (we[i]) flags[i] <= new_flags[i];
         end
      end
   end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX->MEM pipeline register with flag ownership. A latched HLT freezes the
// stage until reset so nothing after the halt reaches MEM or the flags.
module ex_mem_flag_stage
   import wisc_pkg::*;
#(
   parameter int DW = 16,
   parameter int RW = 4
) (
   input logic                clk,
   input logic                rst,
   ex_mem_flag_stage_if.slave bus
);

   logic          valid_p1;
   logic          reg_wr_p1;
   logic          mem_rd_en_p1;
   logic          mem_wr_en_p1;
   logic          halt_p1;
   logic [3:0]    opcode_p1;
   logic [DW-1:0] result_p1;
   logic [DW-1:0] store_data_p1;
   logic [RW-1:0] rd_p1;

   logic          advance;
   logic          load;
   logic          flag_qual;
   logic [2:0]    flags;

   // The halt freeze behaves like a permanent stall; ex_valid=0 is a flush.
   assign advance   = ~bus.stall & ~halt_p1;
   assign load      = bus.ex_valid & ~bus.flush;
   assign flag_qual = advance & load & ~rst;

   // EX -> MEM boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_p1      <= 1'b0;
         reg_wr_p1     <= 1'b0;
         mem_rd_en_p1  <= 1'b0;
         mem_wr_en_p1  <= 1'b0;
         halt_p1       <= 1'b0;
         opcode_p1     <= '0;
         result_p1     <= '0;
         store_data_p1 <= '0;
         rd_p1         <= '0;
      end else if (advance) begin
         if (load) begin
            valid_p1      <= 1'b1;
            reg_wr_p1     <= bus.ex_reg_wr;
            mem_rd_en_p1  <= bus.ex_mem_rd;
            mem_wr_en_p1  <= bus.ex_mem_wr;
            halt_p1       <= bus.ex_halt;
            opcode_p1     <= bus.ex_opcode;
            result_p1     <= bus.ex_result;
            store_data_p1 <= bus.ex_store_data;
            rd_p1         <= bus.ex_rd;
         end else begin
            valid_p1      <= 1'b0;
            reg_wr_p1     <= 1'b0;
            mem_rd_en_p1  <= 1'b0;
            mem_wr_en_p1  <= 1'b0;
            halt_p1       <= 1'b0;
            opcode_p1     <= '0;
            result_p1     <= '0;
            store_data_p1 <= '0;
            rd_p1         <= '0;
         end
      end
   end

   flag_reg #(.DW(DW)) u_flag_reg (
      .clk       (clk),
      .rst       (rst),
      .wr_qual   (flag_qual),
      .opcode    (bus.ex_opcode),
      .result    (bus.ex_result),
      .ovfl      (bus.ex_ovfl),
      .flags     (flags),
      .flags_fwd (bus.flags_fwd)
   );

   assign bus.mem_valid      = valid_p1;
   assign bus.mem_reg_wr     = reg_wr_p1;
   assign bus.mem_mem_rd     = mem_rd_en_p1;
   assign bus.mem_mem_wr     = mem_wr_en_p1;
   assign bus.mem_halt       = halt_p1;
   assign bus.mem_opcode     = opcode_p1;
   assign bus.mem_result     = result_p1;
   assign bus.mem_store_data = store_data_p1;
   assign bus.mem_rd         = rd_p1;
   assign bus.flag_z         = flags[FLAG_Z];
   assign bus.flag_v         = flags[FLAG_V];
   assign bus.flag_n         = flags[FLAG_N];

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed bench for ex_mem_flag_stage: reset, flag writer classes, bypass,
// stall/flush priority, halt freeze and reset during stall.
module tb_ex_mem_flag_stage;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ex_mem_flag_stage_if #(.DW(16), .RW(4)) bus ();

   ex_mem_flag_stage #(.DW(16), .RW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [15:0] res, input logic ovfl,
                        input logic reg_wr, input logic halt, input logic valid);
      bus.ex_opcode     = op;
      bus.ex_result     = res;
      bus.ex_ovfl       = ovfl;
      bus.ex_reg_wr     = reg_wr;
      bus.ex_halt       = halt;
      bus.ex_valid      = valid;
      bus.ex_store_data = res ^ 16'h5A5A;
      bus.ex_rd         = op ^ 4'h3;
      bus.ex_mem_rd     = 1'b0;
      bus.ex_mem_wr     = 1'b0;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] flags_now();
      return {bus.flag_z, bus.flag_v, bus.flag_n};
   endfunction

   initial begin
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      drive(4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset for two cycles
      rst = 1'b1;
      tick();
      tick();
      chk("rst_mem_valid", bus.mem_valid, 1'b0);
      chk("rst_mem_ctrl", {bus.mem_reg_wr, bus.mem_mem_rd, bus.mem_mem_wr, bus.mem_halt}, 4'b0000);
      chk("rst_mem_data", {bus.mem_opcode, bus.mem_rd, bus.mem_result, bus.mem_store_data}, 40'h0);
      chk("rst_flags", flags_now(), 3'b000);
      chk("rst_fwd", bus.flags_fwd, 3'b000);
      rst = 1'b0;

      // ADD result 0 with overflow
      drive(4'h0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("add_fwd", bus.flags_fwd, 3'b110);
      tick();
      chk("add_flags", flags_now(), 3'b110);
      chk("add_mem_valid", bus.mem_valid, 1'b1);
      chk("add_mem_reg_wr", bus.mem_reg_wr, 1'b1);
      chk("add_mem_rd", bus.mem_rd, 4'h3);
      chk("add_mem_store", bus.mem_store_data, 16'h5A5A);

      // SUB negative, then PADDSB zero leaves flags alone
      drive(4'h1, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("sub_fwd", bus.flags_fwd, 3'b001);
      tick();
      chk("sub_flags", flags_now(), 3'b001);
      chk("sub_mem_result", bus.mem_result, 16'h8001);
      drive(4'h7, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("paddsb_fwd", bus.flags_fwd, 3'b001);
      tick();
      chk("paddsb_flags", flags_now(), 3'b001);
      chk("paddsb_mem_op", bus.mem_opcode, 4'h7);

      // ADD 8000 with overflow -> 011; XOR 0 -> 111; SLL 4 -> 011
      drive(4'h0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      chk("add2_flags", flags_now(), 3'b011);
      drive(4'h2, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("xor_fwd", bus.flags_fwd, 3'b111);
      tick();
      chk("xor_flags", flags_now(), 3'b111);
      drive(4'h4, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("sll_fwd", bus.flags_fwd, 3'b011);
      tick();
      chk("sll_flags", flags_now(), 3'b011);

      // Stall for two cycles holds everything; fwd shows old flags
      bus.stall = 1'b1;
      drive(4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("stall_fwd", bus.flags_fwd, 3'b011);
      tick();
      tick();
      chk("stall_mem_op", bus.mem_opcode, 4'h4);
      chk("stall_mem_result", bus.mem_result, 16'h0004);
      chk("stall_flags", flags_now(), 3'b011);
      bus.stall = 1'b0;
      #1;
      chk("unstall_fwd", bus.flags_fwd, 3'b100);
      tick();
      chk("unstall_flags", flags_now(), 3'b100);
      chk("unstall_mem_op", bus.mem_opcode, 4'h0);
      chk("unstall_mem_result", bus.mem_result, 16'h0000);

      // Stall and flush together: stall wins
      bus.stall = 1'b1;
      bus.flush = 1'b1;
      drive(4'h1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      chk("stallflush_valid", bus.mem_valid, 1'b1);
      chk("stallflush_flags", flags_now(), 3'b100);
      bus.stall = 1'b0;

      // Flush of an ADD loads a bubble and leaves flags
      drive(4'h0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("flush_fwd", bus.flags_fwd, 3'b100);
      tick();
      chk("flush_valid", bus.mem_valid, 1'b0);
      chk("flush_reg_wr", bus.mem_reg_wr, 1'b0);
      chk("flush_flags", flags_now(), 3'b100);
      bus.flush = 1'b0;

      // ex_valid=0 is a bubble too
      drive(4'h0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      chk("novalid_reg_wr", bus.mem_reg_wr, 1'b0);
      chk("novalid_flags", flags_now(), 3'b100);

      // HLT latched, then a later ADD is ignored
      drive(4'hF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      chk("hlt_mem_halt", bus.mem_halt, 1'b1);
      chk("hlt_flags", flags_now(), 3'b100);
      drive(4'h0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      tick();
      chk("post_hlt_op", bus.mem_opcode, 4'hF);
      chk("post_hlt_halt", bus.mem_halt, 1'b1);
      chk("post_hlt_flags", flags_now(), 3'b100);

      // Reset during stall clears state
      bus.stall = 1'b1;
      rst = 1'b1;
      tick();
      chk("rst_stall_halt", bus.mem_halt, 1'b0);
      chk("rst_stall_valid", bus.mem_valid, 1'b0);
      chk("rst_stall_flags", flags_now(), 3'b000);
      rst = 1'b0;
      bus.stall = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
